// File: rtl/tl_switch_param_pkg.sv
// Shared types and helpers for the parametrised transaction-layer switch.
package tl_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    localparam int DEFAULT_BAJO = 1;

    function automatic int default_alto(input int depth);
        return depth - 2;
    endfunction

    // Destination channel lives in the top dsw bits of a dw-bit word.
    function automatic int unsigned dest_field(input logic [63:0] word,
                                               input int unsigned dw,
                                               input int unsigned dsw);
        return 32'((word >> (dw - dsw)) & ((64'd1 << dsw) - 64'd1));
    endfunction

endpackage

// File: rtl/tl_switch_param_fifo_sync.sv
// Synchronous FIFO with occupancy count. REG_OUT=1 registers data_out on pop;
// REG_OUT=0 exposes the head word combinationally (first-word fall-through).
module fifo_sync #(
    parameter int DW      = 10,
    parameter int DEPTH   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          data_in,
    output logic [DW-1:0]          data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [DW-1:0] data_out_q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_out_q <= '0;
                end else if (do_pop) begin
                    data_out_q <= mem_q[rd_ptr_q];
                end
            end
            assign data_out = data_out_q;
        end else begin : g_fwft
            assign data_out = mem_q[rd_ptr_q];
        end
    endgenerate

endmodule

// File: rtl/tl_switch_param.sv
// NCH x NCH transaction-layer switch: input FIFOs drained one word per cycle by a
// round-robin arbiter into destination output FIFOs, under a control FSM.
module tl_switch_param
    import tl_pkg::*;
#(
    parameter int  NCH   = 4,
    parameter int  DW    = 10,
    parameter int  DEPTH = 8,
    parameter int  CW    = 5,
    localparam int TW    = $clog2(DEPTH) + 1,
    localparam int DSW   = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [TW-1:0]     umbral_alto,
    input  logic [TW-1:0]     umbral_bajo,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH-1:0]    push,
    input  logic [NCH-1:0]    pop,
    output logic [NCH*DW-1:0] data_out,
    output logic [NCH-1:0]    in_full,
    output logic [NCH-1:0]    in_almost_full,
    output logic [NCH-1:0]    out_empty,
    output logic [NCH-1:0]    out_almost_empty,
    input  logic              req,
    input  logic [DSW-1:0]    idx,
    output logic              valid_contador,
    output logic [CW-1:0]     contador_out,
    output logic [2:0]        state,
    output logic              error,
    output logic              idle
);
    state_e        state_q;
    logic [TW-1:0] alto_q, bajo_q;
    logic [DSW-1:0] rr_q;
    logic          valid_q;
    logic [CW-1:0] cout_q;
    logic [CW-1:0] cnt_q [NCH];

    logic [DW-1:0]  in_head   [NCH];
    logic [TW-1:0]  in_count  [NCH];
    logic [TW-1:0]  out_count [NCH];
    logic [DSW-1:0] in_dest   [NCH];
    logic [NCH-1:0] in_full_w, in_empty_w, out_full_w, out_empty_w;
    logic [NCH-1:0] in_push, in_pop, out_push, out_pop;
    logic [NCH-1:0] push_err, pop_err, eligible;

    logic           ops_en, err_any, move, grant_valid;
    logic [DSW-1:0] grant_idx, grant_dest;
    logic [DW-1:0]  grant_word;

    assign ops_en  = (state_q == S_INIT) || (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign err_any = ops_en && ((|push_err) || (|pop_err));

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            fifo_sync #(.DW(DW), .DEPTH(DEPTH), .REG_OUT(1'b0)) u_in (
                .clk, .reset,
                .push(in_push[gi]), .pop(in_pop[gi]),
                .data_in(data_in[gi*DW +: DW]), .data_out(in_head[gi]),
                .count(in_count[gi]), .full(in_full_w[gi]), .empty(in_empty_w[gi])
            );
            fifo_sync #(.DW(DW), .DEPTH(DEPTH), .REG_OUT(1'b1)) u_out (
                .clk, .reset,
                .push(out_push[gi]), .pop(out_pop[gi]),
                .data_in(grant_word), .data_out(data_out[gi*DW +: DW]),
                .count(out_count[gi]), .full(out_full_w[gi]), .empty(out_empty_w[gi])
            );

            assign in_dest[gi]  = DSW'(dest_field(64'(in_head[gi]), DW, DSW));
            // The full check only matters when alto exceeds DEPTH.
            assign eligible[gi] = !in_empty_w[gi] && !out_full_w[in_dest[gi]]
                                  && (out_count[in_dest[gi]] < alto_q);

            assign in_pop[gi]   = move && (grant_idx == DSW'(gi));
            assign out_push[gi] = move && (grant_dest == DSW'(gi));
            assign push_err[gi] = push[gi] && in_full_w[gi] && !in_pop[gi];
            assign in_push[gi]  = ops_en && push[gi] && !push_err[gi];
            assign pop_err[gi]  = pop[gi] && out_empty_w[gi];
            assign out_pop[gi]  = ops_en && pop[gi] && !out_empty_w[gi];

            assign in_almost_full[gi]   = (in_count[gi] >= alto_q);
            assign out_almost_empty[gi] = (out_count[gi] <= bajo_q);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_q[gi] <= '0;
                end else if (out_pop[gi]) begin
                    cnt_q[gi] <= cnt_q[gi] + CW'(1);
                end
            end
        end
    endgenerate

    // Scan from rr_q downwards in priority so the closest eligible channel wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            if (eligible[rr_q + DSW'(off)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_q + DSW'(off);
            end
        end
    end

    assign move       = grant_valid && (state_q == S_ACTIVE);
    assign grant_word = in_head[grant_idx];
    assign grant_dest = in_dest[grant_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            alto_q  <= TW'(default_alto(DEPTH));
            bajo_q  <= TW'(DEFAULT_BAJO);
            rr_q    <= '0;
            valid_q <= 1'b0;
            cout_q  <= '0;
        end else begin
            valid_q <= (state_q == S_IDLE) && req;
            if ((state_q == S_IDLE) && req) cout_q <= cnt_q[idx];
            if (move) rr_q <= grant_idx + DSW'(1);
            case (state_q)
                S_RESET: state_q <= S_INIT;
                S_INIT: begin
                    alto_q <= umbral_alto;
                    bajo_q <= umbral_bajo;
                    if (err_any)   state_q <= S_ERROR;
                    else if (!init) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (err_any)            state_q <= S_ERROR;
                    else if (init)          state_q <= S_INIT;
                    else if (!(&in_empty_w)) state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (err_any)   state_q <= S_ERROR;
                    else if (init) state_q <= S_INIT;
                    else if ((&in_empty_w) && (&out_empty_w) && !move) state_q <= S_IDLE;
                end
                default: state_q <= S_ERROR;
            endcase
        end
    end

    assign in_full        = in_full_w;
    assign out_empty      = out_empty_w;
    assign valid_contador = valid_q;
    assign contador_out   = cout_q;
    assign state          = state_q;
    assign error          = (state_q == S_ERROR);
    assign idle           = (state_q == S_IDLE);

endmodule

// File: tb/tb_tl_switch_param.sv
// Directed and randomized bench for tl_switch_param against a queue-based reference model.
module tb_tl_switch_param;
    localparam int NCH = 4, DW = 10, DEPTH = 8, CW = 5, TW = 4, DSW = 2;
    typedef logic [DW-1:0] word_t;

    logic              clk = 1'b0;
    logic              reset, init, req;
    logic [TW-1:0]     umbral_alto, umbral_bajo;
    logic [NCH*DW-1:0] data_in, data_out;
    logic [NCH-1:0]    push, pop, in_full, in_almost_full, out_empty, out_almost_empty;
    logic [DSW-1:0]    idx;
    logic              valid_contador, error, idle;
    logic [CW-1:0]     contador_out;
    logic [2:0]        state;

    always #5 clk = ~clk;

    tl_switch_param #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .data_in(data_in), .push(push), .pop(pop), .data_out(data_out),
        .in_full(in_full), .in_almost_full(in_almost_full),
        .out_empty(out_empty), .out_almost_empty(out_almost_empty),
        .req(req), .idx(idx), .valid_contador(valid_contador),
        .contador_out(contador_out), .state(state), .error(error), .idle(idle)
    );

    int checks = 0, errors = 0, cyc = 0;

    // Reference model: FIFOs as queues, states as plain numbers 0..4.
    word_t inq [NCH][$];
    word_t outq[NCH][$];
    int    m_state, m_alto, m_bajo, m_rr, m_cout;
    int    m_cnt [NCH];
    word_t m_dout[NCH];
    logic  m_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int  in_sz[NCH];
        int  out_sz[NCH];
        bit  ops, mv, err, all_empty, any_in;
        int  g, md, ns;
        word_t w;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                inq[i].delete(); outq[i].delete(); m_cnt[i] = 0; m_dout[i] = '0;
            end
            m_state = 0; m_alto = DEPTH - 2; m_bajo = 1; m_rr = 0; m_valid = 1'b0; m_cout = 0;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            in_sz[i] = inq[i].size(); out_sz[i] = outq[i].size();
        end
        ops = (m_state >= 1) && (m_state <= 3);
        mv = 0; g = 0; md = 0;
        if (m_state == 3) begin
            for (int off = 0; off < NCH; off++) begin
                int ch;
                ch = (m_rr + off) % NCH;
                if (!mv && in_sz[ch] > 0) begin
                    int d;
                    d = int'(inq[ch][0] >> (DW - DSW));
                    if (out_sz[d] < m_alto && out_sz[d] < DEPTH) begin
                        mv = 1; g = ch; md = d;
                    end
                end
            end
        end
        err = 0; all_empty = 1; any_in = 0;
        for (int i = 0; i < NCH; i++) begin
            if (ops && push[i] && in_sz[i] == DEPTH && !(mv && g == i)) err = 1;
            if (ops && pop[i] && out_sz[i] == 0) err = 1;
            if (in_sz[i] > 0) begin any_in = 1; all_empty = 0; end
            if (out_sz[i] > 0) all_empty = 0;
        end
        m_valid = (m_state == 2) && req;
        if (m_valid) m_cout = m_cnt[idx];
        if (ops) begin
            for (int k = 0; k < NCH; k++) begin
                if (pop[k] && out_sz[k] > 0) begin
                    m_dout[k] = outq[k].pop_front();
                    m_cnt[k]  = (m_cnt[k] + 1) % (1 << CW);
                end
            end
        end
        if (mv) begin
            w = inq[g].pop_front(); outq[md].push_back(w); m_rr = (g + 1) % NCH;
        end
        if (ops) begin
            for (int i = 0; i < NCH; i++)
                if (push[i] && (in_sz[i] < DEPTH || (mv && g == i)))
                    inq[i].push_back(data_in[i*DW +: DW]);
        end
        case (m_state)
            0: ns = 1;
            1: begin
                m_alto = int'(umbral_alto); m_bajo = int'(umbral_bajo);
                ns = err ? 4 : (init ? 1 : 2);
            end
            2: ns = err ? 4 : (init ? 1 : (any_in ? 3 : 2));
            3: ns = err ? 4 : (init ? 1 : ((all_empty && !mv) ? 2 : 3));
            default: ns = 4;
        endcase
        m_state = ns;
    endtask

    task automatic check_all();
        logic [NCH-1:0]    e_inf, e_inaf, e_oe, e_oae;
        logic [NCH*DW-1:0] e_do;
        for (int i = 0; i < NCH; i++) begin
            e_inf[i]  = (inq[i].size() == DEPTH);
            e_inaf[i] = (inq[i].size() >= m_alto);
            e_oe[i]   = (outq[i].size() == 0);
            e_oae[i]  = (outq[i].size() <= m_bajo);
            e_do[i*DW +: DW] = m_dout[i];
        end
        chk("state", 64'(state), 64'(m_state));
        chk("error", 64'(error), 64'(m_state == 4));
        chk("idle", 64'(idle), 64'(m_state == 2));
        chk("in_full", 64'(in_full), 64'(e_inf));
        chk("in_almost_full", 64'(in_almost_full), 64'(e_inaf));
        chk("out_empty", 64'(out_empty), 64'(e_oe));
        chk("out_almost_empty", 64'(out_almost_empty), 64'(e_oae));
        chk("data_out", 64'(data_out), 64'(e_do));
        chk("valid_contador", 64'(valid_contador), 64'(m_valid));
        chk("contador_out", 64'(contador_out), 64'(m_cout));
    endtask

    task automatic step(input logic rst_n, input logic ini, input logic [NCH-1:0] ps,
                        input logic [NCH*DW-1:0] pd, input logic [NCH-1:0] pp,
                        input logic rq, input logic [DSW-1:0] ix);
        reset = rst_n; init = ini; push = ps; data_in = pd; pop = pp; req = rq; idx = ix;
        model_update();
        @(posedge clk); #1;
        cyc++;
        check_all();
        $display("cyc %0d rst=%b init=%b push=%b pop=%b req=%b state=%0d", cyc, rst_n, ini, ps, pp, rq, state);
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && m_state != 2; k++) begin
            logic [NCH-1:0] pp;
            for (int i = 0; i < NCH; i++) pp[i] = (outq[i].size() > 0);
            step(1'b1, 1'b0, '0, '0, pp, 1'b0, '0);
        end
        chk("drain_idle", 64'(state), 64'd2);
    endtask

    task automatic random_phase(input int n);
        for (int s = 0; s < n; s++) begin
            logic [NCH-1:0]    ps, pp;
            logic [NCH*DW-1:0] pd;
            for (int i = 0; i < NCH; i++) begin
                ps[i] = ($urandom_range(0, 1) == 1) && (inq[i].size() < DEPTH);
                pp[i] = ($urandom_range(0, 2) == 0) && (outq[i].size() > 0);
                pd[i*DW +: DW] = word_t'($urandom);
            end
            step(1'b1, 1'b0, ps, pd, pp, $urandom_range(0, 3) == 0, DSW'($urandom_range(0, NCH - 1)));
        end
    endtask

    initial begin
        logic [NCH*DW-1:0] pdv;
        word_t             wexp;
        reset = 1'b0; init = 1'b0; req = 1'b0; idx = '0;
        push = '0; pop = '0; data_in = '0;
        umbral_alto = 4'd5; umbral_bajo = 4'd3;

        // Reset
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'hF);
        chk("rst_data_out", 64'(data_out), 64'd0);

        // Init with alto=5, bajo=3
        repeat (3) step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        chk("init_state", 64'(state), 64'd1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("init_to_idle", 64'(state), 64'd2);
        chk("init_oae", 64'(out_almost_empty), 64'hF);

        // Route 0x101 from ch0 to out1
        step(1'b1, 1'b0, 4'b0001, 40'h101, '0, 1'b0, '0);
        idle_steps(1);
        chk("route_lat1", 64'(out_empty), 64'hF);
        idle_steps(1);
        chk("route_lat2", 64'(out_empty), 64'hD);
        step(1'b1, 1'b0, '0, '0, 4'b0010, 1'b0, '0);
        chk("route_pop", 64'(data_out[19:10]), 64'h101);
        drain();
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 2'd1);
        chk("cnt_valid", 64'(valid_contador), 64'd1);
        chk("cnt_value", 64'(contador_out), 64'd1);

        // Backpressure: six words to out0 with alto=5
        for (int j = 0; j < 6; j++) begin
            pdv = '0; pdv[DW-1:0] = word_t'(16 + j);
            step(1'b1, 1'b0, 4'b0001, pdv, '0, 1'b0, '0);
        end
        idle_steps(8);
        chk("bp_state", 64'(state), 64'd3);
        chk("bp_out0_nonempty", 64'(out_empty[0]), 64'd0);
        step(1'b1, 1'b0, '0, '0, 4'b0001, 1'b0, '0);
        chk("bp_pop", 64'(data_out[9:0]), 64'h010);
        idle_steps(2);
        drain();

        // Reset mid-operation loses in-flight words
        step(1'b1, 1'b0, 4'b0010, {10'h0, 10'h0, 10'h3AA, 10'h0}, '0, 1'b0, '0);
        idle_steps(1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_out_empty", 64'(out_empty), 64'hF);
        umbral_alto = 4'd6; umbral_bajo = 4'd1;
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);

        // Fairness: all inputs target out2 at once
        step(1'b1, 1'b0, 4'hF, {10'h203, 10'h202, 10'h201, 10'h200}, '0, 1'b0, '0);
        idle_steps(5);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, '0, '0, 4'b0100, 1'b0, '0);
            wexp = word_t'(10'h200 + k);
            chk($sformatf("fair_%0d", k), 64'(data_out[29:20]), 64'(wexp));
        end
        drain();

        // Randomized traffic under two threshold settings
        umbral_alto = 4'd9; umbral_bajo = 4'd2;
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        random_phase(150);
        umbral_alto = 4'd3; umbral_bajo = 4'd0;
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        random_phase(150);
        drain();

        // Pop of an empty output is sticky until reset
        step(1'b1, 1'b0, '0, '0, 4'b1000, 1'b0, '0);
        chk("err_pop_state", 64'(state), 64'd4);
        chk("err_pop_flag", 64'(error), 64'd1);
        step(1'b1, 1'b0, 4'hF, {10'h0C1, 10'h1C2, 10'h2C3, 10'h3C4}, 4'hF, 1'b1, 2'd0);
        idle_steps(3);
        chk("err_sticky", 64'(state), 64'd4);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("err_clear", 64'(error), 64'd0);

        // Push into a full input FIFO while in INIT
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
        for (int j = 0; j < DEPTH; j++) begin
            pdv = '0; pdv[DW-1:0] = word_t'(10'h040 + j);
            step(1'b1, 1'b1, 4'b0001, pdv, '0, 1'b0, '0);
        end
        chk("full_flag", 64'(in_full[0]), 64'd1);
        step(1'b1, 1'b1, 4'b0001, 40'h0FF, '0, 1'b0, '0);
        chk("full_err_state", 64'(state), 64'd4);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("final_state", 64'(state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
